// File: rtl/rr_arbiter_pkg.sv
// rr_arbiter_pkg: shared types and helpers for rr_arbiter (RR_ARB_TIMEOUT_EN enables forced release)
package rr_arbiter_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  function automatic int RR_ARB_IDX_W(input int width);
    return $clog2(width);
  endfunction
  function automatic int RR_ARB_PTR_RST(input int width);
    return width - 1;
  endfunction
endpackage

// File: rtl/pri_enc_lsb.sv
// pri_enc_lsb: find-first encoder returning the lowest set index and a found flag
module pri_enc_lsb import rr_arbiter_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]                   req,
  output logic [RR_ARB_IDX_W(WIDTH)-1:0]     idx,
  output logic                               found
);
  localparam int IW = RR_ARB_IDX_W(WIDTH);
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (req[i]) begin
        idx = IW'(i);
        found = 1'b1;
      end
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin hold-until-release arbiter; RR_ARB_TIMEOUT_EN adds MAX_HOLD forced release
module rr_arbiter import rr_arbiter_pkg::*; #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               req,
  output logic [WIDTH-1:0]               gnt,
  output logic [RR_ARB_IDX_W(WIDTH)-1:0] gnt_idx,
  output logic                           gnt_vld
);
  localparam int IW = RR_ARB_IDX_W(WIDTH);
  localparam logic [IW-1:0] PTR_RST = IW'(RR_ARB_PTR_RST(WIDTH));
  if (WIDTH < 2 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("rr_arbiter: WIDTH must be >= 2 and MAX_HOLD >= 1");
  end
  arb_state_t state;
  logic [IW-1:0] ptr, enc_idx, nxt_idx, new_idx;
  logic [IW:0] base, sum;
  logic [WIDTH-1:0] sreq, rot;
  logic found, held, expired, keep, take;
  // The current grantee never competes in the search; it only wins back by re-grant after timeout.
  assign sreq = req & ~gnt;
  assign base = {1'b0, ptr} + (IW+1)'(1);
  assign rot = WIDTH'({sreq, sreq} >> base);
  pri_enc_lsb #(.WIDTH(WIDTH)) u_enc (.req(rot), .idx(enc_idx), .found(found));
  assign sum = {1'b0, enc_idx} + base;
  assign nxt_idx = sum >= (IW+1)'(WIDTH) ? IW'(sum - (IW+1)'(WIDTH)) : IW'(sum);
  assign held = state == GRANT && req[gnt_idx];
`ifdef RR_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hcnt;
  assign expired = held && hcnt == HW'(MAX_HOLD - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) hcnt <= '0;
    else hcnt <= keep ? hcnt + HW'(1) : '0;
`else
  assign expired = 1'b0;
`endif
  assign keep = held && !expired;
  assign take = found || expired;
  assign new_idx = found ? nxt_idx : gnt_idx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ptr <= PTR_RST;
      gnt <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
    end else if (!keep) begin
      state <= take ? GRANT : IDLE;
      ptr <= take ? new_idx : ptr;
      gnt <= take ? WIDTH'(1) << new_idx : '0;
      gnt_idx <= take ? new_idx : '0;
      gnt_vld <= take;
    end
endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that shares one resource among `WIDTH` requesters with hold-until-release semantics. It uses a find-first priority encoder to select the next grantee. The search starts just after the last granted index, so no requester starves. It sits between a bank of requesters and a single shared datapath, and drives that datapath's select/enable from registered grant outputs.

## Interface
- `WIDTH`, 8: number of requesters; must be ≥ 2.
- `MAX_HOLD`, 16: maximum consecutive grant cycles per tenure; used only when `RR_ARB_TIMEOUT_EN` is defined; must be ≥ 1.
- `clk` input, 1: single clock, rising-edge.
- `rst` input, 1: reset, asynchronous and active-high.
- `req` input, `WIDTH`: request vector; bit i held high while requester i wants or holds the resource.
- `gnt` output, `WIDTH`: one-hot grant, or all-zero when idle.
- `gnt_idx` output, `$clog2(WIDTH)`: binary index of the current grantee; 0 when idle.
- `gnt_vld` output, 1: high whenever `gnt` is non-zero.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: `gnt[gnt_idx]` asserted.
- Round-robin pointer `ptr`: last granted index. The search order is `ptr+1, ptr+2, …, WIDTH-1, 0, …, ptr`, wrapping modulo `WIDTH`.
- IDLE → GRANT: any `req` bit set. Grant the first set bit in search order and load `ptr` with that index.
- GRANT, `req[gnt_idx]` still high: hold the grant unchanged (hold-until-release).
- GRANT, `req[gnt_idx]` low, other requests present: switch directly to the next grantee in search order. There is no idle bubble.
- GRANT, `req[gnt_idx]` low, `req` all-zero: → IDLE. `gnt`, `gnt_idx` and `gnt_vld` clear.
- `ptr` updates only when a new grant is issued. It is unchanged in IDLE.
- Requests that arrive while another requester holds the grant are only considered at release.
- Simultaneous release and re-request by the same requester in one cycle: the requester is treated as released, and the bit is considered only in its normal search position (last).
- Invariants, checked by assertion in the bench:
  - `gnt` is one-hot or zero.
  - `gnt_vld == |gnt`.
  - `gnt == (gnt_vld << gnt_idx)`.

## Timing
- All outputs are registered. There is no combinational path from `req` to any output.
- Request-to-grant latency is 1 cycle: `req` sampled at edge N produces `gnt` valid after edge N.
- Release-to-next-grant latency is 1 cycle: the new grantee replaces the old one on the same edge.
- Release-to-idle latency is 1 cycle.
- Reset values, applied asynchronously and held while `rst` is high:
  - `gnt`=0, `gnt_idx`=0, `gnt_vld`=0.
  - state=IDLE, `ptr`=`WIDTH-1`, so the first search starts at index 0.
  - hold counter=0.
- Reset mid-grant drops the grant immediately, without waiting for a clock edge.

## Configuration
- `RR_ARB_TIMEOUT_EN` defined:
  - A hold counter of width `$clog2(MAX_HOLD+1)` counts grant cycles. It resets to 0 on every new grant, including a forced re-grant to the same index.
  - When a grant has been visible for `MAX_HOLD` cycles and `req[gnt_idx]` is still high, the grant is forcibly released on the next edge. The next grantee is chosen with `gnt_idx` masked out of the search.
  - If no other request is pending, the same requester is re-granted with no gap, and the counter restarts.
- `RR_ARB_TIMEOUT_EN` not defined:
  - There is no counter and no forced release.
  - A requester may hold the grant indefinitely.
  - `MAX_HOLD` is ignored.

## Structure
- Shared package `rr_arbiter_pkg`:
  - state enum `arb_state_t` {IDLE, GRANT}.
  - `RR_ARB_IDX_W(width)` helper via `$clog2`.
  - reset constant for `ptr`.
- One sub-module, `pri_enc_lsb #(WIDTH)`: combinational find-first encoder returning the lowest set index plus a found flag.
- The arbiter rotates `req` right by `ptr+1`, encodes the result with `pri_enc_lsb`, then adds `ptr+1` modulo `WIDTH` to recover the absolute index.

## Test plan
- **Reset:** with `gnt`=8'h10 active, assert `rst` between edges. `gnt`/`gnt_vld`/`gnt_idx` go to 0 before the next edge. After release, with `req`=8'h01, `gnt`=8'h01 one cycle later.
- **Rotation:** `req`=8'hFF; each grantee drops its `req` for exactly its first granted cycle's following edge, then re-raises. The grant sequence is 0,1,2,…,7,0 with no idle cycles.
- **Wrap search:** grant index 5, then release. Set `req`=8'h21 on that cycle. The next grant is index 0 (search 6,7,0), not 5.
- **Hold:** `req`=8'h80 held 10 cycles, so `gnt`=8'h80 for 10 cycles. Drop `req`; `gnt`=0 and `gnt_vld`=0 one cycle later.
- **Timeout** (`RR_ARB_TIMEOUT_EN`, `MAX_HOLD`=4): `req`=8'h06 held constantly. `gnt` alternates 8'h02 ×4, 8'h04 ×4, 8'h02 ×4. With `req`=8'h02 alone, `gnt` stays 8'h02 continuously.
- **No-timeout build:** the same `req`=8'h06 stimulus. `gnt` stays 8'h02 indefinitely.
